mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle main control FSM that sequences the instruction fetch unit and the rest of the MIPS datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memory.
- Asserts the fetch unit's pc_we/branch/jump/jr exactly once per retired instruction.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
LINK_REG, 31, register index written by JAL (driven on link_idx)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instr[31:26] from instruction memory; captured on ir_we
funct  in  6  instr[5:0]; captured on ir_we
imem_ready  in  1  instruction memory has valid data this cycle
dmem_ready  in  1  data memory read/write completes this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  capture instruction register
pc_we  out  1  PC write enable to fetch unit
branch  out  1  select branch path (fetch unit gates with zero internally)
jump  out  1  select jump path
jr  out  1  jump target from register (valid only with jump)
alu_src  out  1  0=rt, 1=sign-extended imm16
alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
dmem_req  out  1  data memory request
mem_we  out  1  data memory write
reg_we  out  1  register file write
reg_dst  out  2  00=rt, 01=rd, 10=link_idx
mem_to_reg  out  1  writeback data from memory
link_sel  out  1  writeback data = PC+4
link_idx  out  5  constant LINK_REG
state  out  3  current FSM state (debug)
illegal  out  1  sticky illegal-opcode flag
retired  out  CNT_W  count of pc_we pulses

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (async): state=FETCH, captured opcode/funct=0, illegal=0, retired=0. While reset is high, all outputs are 0.
- Reset mid-instruction: abandons the instruction; no pc_we; resumes at FETCH.
- Outputs are combinational from state, captured opcode/funct, and the ready inputs. Anything not listed for a state is 0.
- FETCH: imem_req=1. Stays in FETCH until imem_ready. On the imem_ready cycle, ir_we=1, opcode/funct are captured, next state DECODE.
- DECODE, by captured opcode/funct:
  - J(02): pc_we=1, jump=1; next FETCH.
  - JR (R-type 00, funct 08): pc_we=1, jump=1, jr=1; next FETCH.
  - JAL(03): next WB.
  - R-type ADD(20)/SUB(22)/SLT(2A), ADDI(08), XORI(0E), LW(23), SW(2B), BNE(05): next EXEC.
  - Any other opcode, or R-type with another funct: next TRAP.
- EXEC:
  - alu_src=1 for ADDI/XORI/LW/SW.
  - alu_op: ADD for ADD/ADDI/LW/SW; SUB for SUB/BNE; XOR for XORI; SLT for SLT.
  - BNE: branch=1, pc_we=1; next FETCH. The ALU result is the zero used by the fetch unit this cycle.
  - LW/SW: next MEM. All others: next WB.
- MEM:
  - dmem_req=1, alu_op=ADD, alu_src=1; mem_we=1 for SW.
  - Stays in MEM until dmem_ready.
  - On dmem_ready: SW asserts pc_we=1 and goes to FETCH; LW goes to WB.
- WB (one cycle, next FETCH):
  - reg_we=1, pc_we=1.
  - R-type: reg_dst=01, alu_op held as in EXEC.
  - ADDI/XORI: reg_dst=00, alu_src=1, alu_op held.
  - LW: reg_dst=00, mem_to_reg=1.
  - JAL: reg_dst=10, link_sel=1, jump=1.
- TRAP: illegal=1. No further outputs. Terminal until reset.
- pc_we asserts exactly one cycle per instruction, only in its final state. retired increments by 1 on each pc_we cycle and wraps modulo 2^CNT_W.
- Latency with ready inputs tied high:
  - J/JR: 2 cycles.
  - BNE: 3 cycles.
  - JAL: 3 cycles.
  - ALU ops: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Stall: each extra cycle imem_ready or dmem_ready is low adds exactly one cycle. Outputs hold stable during a stall.

Test Plan:
- Reset released, imem_ready=1, opcode=00/funct=20 (ADD): state sequence 0,1,2,4,0; pc_we and reg_we high only in WB with reg_dst=01; retired=1.
- LW (23) with dmem_ready low 3 cycles in MEM: 8 cycles total; dmem_req high 4 cycles; mem_to_reg=1 and pc_we=1 in WB only.
- BNE (05): pc_we=1, branch=1, alu_op=001 in EXEC (cycle 3), no reg_we. J (02): pc_we=1, jump=1, jr=0 in DECODE. JR (00/08): jump=1, jr=1.
- JAL (03): WB has reg_we=1, reg_dst=10, link_sel=1, jump=1, link_idx=31.
- Opcode 3F: DECODE→TRAP; illegal=1 held for 20 cycles; pc_we never asserted; reset clears illegal=0 and state=0.
- Reset asserted mid-MEM of SW: outputs 0 immediately, no pc_we, retired=0; after release, imem_req=1 in FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: sequences fetch, decode, execute, memory and
// writeback, drives fetch-unit PC controls and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             branch,
  output logic             jump,
  output logic             jr,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             dmem_req,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             link_sel,
  output logic [4:0]       link_idx,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_SLT, C_ADDI, C_XORI, C_LW, C_SW, C_BNE, C_J, C_JR, C_JAL, C_ILL
  } cls_e;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  cls_e       cls;
  logic [2:0] cls_alu_op;

  logic       imem_req_c, ir_we_c, pc_we_c, branch_c, jump_c, jr_c, alu_src_c;
  logic [2:0] alu_op_c;
  logic       dmem_req_c, mem_we_c, reg_we_c, mem_to_reg_c, link_sel_c;
  logic [1:0] reg_dst_c;

  // Instruction class from the captured instruction fields.
  always_comb begin
    cls = C_ILL;
    case (opcode_q)
      OP_RTYPE: begin
        case (funct_q)
          FN_ADD:  cls = C_ADD;
          FN_SUB:  cls = C_SUB;
          FN_SLT:  cls = C_SLT;
          FN_JR:   cls = C_JR;
          default: cls = C_ILL;
        endcase
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      OP_BNE:  cls = C_BNE;
      OP_ADDI: cls = C_ADDI;
      OP_XORI: cls = C_XORI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      default: cls = C_ILL;
    endcase

    cls_alu_op = ALU_ADD;
    case (cls)
      C_SUB, C_BNE: cls_alu_op = ALU_SUB;
      C_XORI:       cls_alu_op = ALU_XOR;
      C_SLT:        cls_alu_op = ALU_SLT;
      default:      cls_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    imem_req_c   = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    branch_c     = 1'b0;
    jump_c       = 1'b0;
    jr_c         = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    dmem_req_c   = 1'b0;
    mem_we_c     = 1'b0;
    reg_we_c     = 1'b0;
    reg_dst_c    = 2'b00;
    mem_to_reg_c = 1'b0;
    link_sel_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c  = 1'b1;
          opcode_d = opcode;
          funct_d  = funct;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          C_J: begin
            pc_we_c = 1'b1;
            jump_c  = 1'b1;
            state_d = S_FETCH;
          end
          C_JR: begin
            pc_we_c = 1'b1;
            jump_c  = 1'b1;
            jr_c    = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL:   state_d = S_WB;
          C_ILL:   state_d = S_TRAP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_src_c = cls inside {C_ADDI, C_XORI, C_LW, C_SW};
        alu_op_c  = cls_alu_op;
        if (cls == C_BNE) begin
          // Fetch unit gates branch with this cycle's ALU zero flag.
          branch_c = 1'b1;
          pc_we_c  = 1'b1;
          state_d  = S_FETCH;
        end else if (cls inside {C_LW, C_SW}) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        alu_op_c   = ALU_ADD;
        alu_src_c  = 1'b1;
        mem_we_c   = (cls == C_SW);
        if (dmem_ready) begin
          if (cls == C_SW) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        state_d  = S_FETCH;
        case (cls)
          C_ADD, C_SUB, C_SLT: begin
            reg_dst_c = 2'b01;
            alu_op_c  = cls_alu_op;
          end
          C_ADDI, C_XORI: begin
            alu_src_c = 1'b1;
            alu_op_c  = cls_alu_op;
          end
          C_LW:  mem_to_reg_c = 1'b1;
          C_JAL: begin
            reg_dst_c  = 2'b10;
            link_sel_c = 1'b1;
            jump_c     = 1'b1;
          end
          default: ;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = pc_we_c ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // All outputs, including the constant link index, are forced low during reset.
  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jr         = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    dmem_req   = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = '0;
    mem_to_reg = 1'b0;
    link_sel   = 1'b0;
    link_idx   = '0;
    state      = '0;
    illegal    = 1'b0;
    retired    = '0;
    if (!reset) begin
      imem_req   = imem_req_c;
      ir_we      = ir_we_c;
      pc_we      = pc_we_c;
      branch     = branch_c;
      jump       = jump_c;
      jr         = jr_c;
      alu_src    = alu_src_c;
      alu_op     = alu_op_c;
      dmem_req   = dmem_req_c;
      mem_we     = mem_we_c;
      reg_we     = reg_we_c;
      reg_dst    = reg_dst_c;
      mem_to_reg = mem_to_reg_c;
      link_sel   = link_sel_c;
      link_idx   = 5'(LINK_REG);
      state      = state_q;
      illegal    = illegal_q;
      retired    = retired_q;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle comparison against a phase-list
// model of each instruction, with directed latency/trap/reset cases and random runs.
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5;
  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_ADDI = 3, K_XORI = 4, K_LW = 5,
                 K_SW = 6, K_BNE = 7, K_J = 8, K_JR = 9, K_JAL = 10, K_ILL = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = '0, funct = '0;
  logic          imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          imem_req, ir_we, pc_we, branch, jump, jr, alu_src;
  logic [2:0]    alu_op;
  logic          dmem_req, mem_we, reg_we;
  logic [1:0]    reg_dst;
  logic          mem_to_reg, link_sel;
  logic [4:0]    link_idx;
  logic [2:0]    state;
  logic          illegal;
  logic [CW-1:0] retired;

  mips_multicycle_ctrl #(.CNT_W(CW), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .branch(branch),
    .jump(jump), .jr(jr), .alu_src(alu_src), .alu_op(alu_op),
    .dmem_req(dmem_req), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .link_sel(link_sel), .link_idx(link_idx),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [25:0] dut_v;
  always_comb dut_v = {imem_req, ir_we, pc_we, branch, jump, jr, alu_src, alu_op,
                       dmem_req, mem_we, reg_we, reg_dst, mem_to_reg, link_sel,
                       link_idx, state, illegal};

  int n_checks = 0;
  int n_err    = 0;

  int            m_ph = PH_F;
  int            m_k  = K_ILL;
  logic [CW-1:0] m_ret = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h20) return K_ADD;
        if (fn == 6'h22) return K_SUB;
        if (fn == 6'h2A) return K_SLT;
        if (fn == 6'h08) return K_JR;
        return K_ILL;
      end
      6'h08:   return K_ADDI;
      6'h0E:   return K_XORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Which phases an instruction class passes through.
  function automatic bit has_phase(input int k, input int ph);
    case (ph)
      PH_F, PH_D: return 1'b1;
      PH_E:       return !(k inside {K_J, K_JR, K_JAL, K_ILL});
      PH_M:       return k inside {K_LW, K_SW};
      PH_W:       return k inside {K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_LW, K_JAL};
      default:    return 1'b0;
    endcase
  endfunction

  // PH_F as the result means the instruction retires after this phase.
  function automatic int next_phase(input int k, input int ph);
    if (k == K_ILL) return PH_T;
    for (int p = ph + 1; p <= PH_W; p++)
      if (has_phase(k, p)) return p;
    return PH_F;
  endfunction

  function automatic logic [2:0] op_of(input int k);
    case (k)
      K_SUB, K_BNE: return 3'd1;
      K_XORI:       return 3'd2;
      K_SLT:        return 3'd3;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic [25:0] exp_vec(input logic ir, input logic dr);
    int ph = m_ph;
    int k  = m_k;
    logic last, pcw, is_r, is_imm;
    logic [2:0] aop;
    logic [1:0] rd;
    is_r   = k inside {K_ADD, K_SUB, K_SLT};
    is_imm = k inside {K_ADDI, K_XORI};
    last   = (ph inside {PH_D, PH_E, PH_M, PH_W}) && (next_phase(k, ph) == PH_F);
    pcw    = last && (ph != PH_M || dr);
    aop    = (ph == PH_E || (ph == PH_W && (is_r || is_imm))) ? op_of(k) : 3'd0;
    rd     = (ph != PH_W) ? 2'd0 : is_r ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
    return {ph == PH_F, (ph == PH_F) && ir, pcw,
            (ph == PH_E) && (k == K_BNE),
            ((ph == PH_D) && (k inside {K_J, K_JR})) || ((ph == PH_W) && (k == K_JAL)),
            (ph == PH_D) && (k == K_JR),
            ((ph == PH_E) && (is_imm || k inside {K_LW, K_SW})) || (ph == PH_M) ||
              ((ph == PH_W) && is_imm),
            aop,
            ph == PH_M, (ph == PH_M) && (k == K_SW), ph == PH_W, rd,
            (ph == PH_W) && (k == K_LW), (ph == PH_W) && (k == K_JAL),
            5'd31, 3'(ph), ph == PH_T};
  endfunction

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic step(input logic ir, input logic dr, input logic [5:0] op,
                      input logic [5:0] fn, output bit ret_ev);
    int nxt;
    imem_ready = ir;
    dmem_ready = dr;
    opcode     = op;
    funct      = fn;
    #1;
    chk("outputs", 64'(dut_v), 64'(exp_vec(ir, dr)));
    chk("retired", 64'(retired), 64'(m_ret));
    ret_ev = 1'b0;
    case (m_ph)
      PH_F: if (ir) begin
        m_k  = classify(op, fn);
        m_ph = PH_D;
      end
      PH_T: ;
      default: if (!(m_ph == PH_M && !dr)) begin
        nxt = next_phase(m_k, m_ph);
        if (nxt == PH_F) begin
          m_ret  = m_ret + 1'b1;
          ret_ev = 1'b1;
        end
        m_ph = nxt;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outputs", 64'(dut_v), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_outputs", 64'(dut_v), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_ph  = PH_F;
    m_ret = '0;
  endtask

  task automatic run_one(input logic [5:0] op, input logic [5:0] fn, input int istall,
                         input int dstall, input bit rnd, input int reset_at,
                         output int cycles);
    bit ev = 1'b0;
    int il = istall;
    int dl = dstall;
    logic ir, dr;
    cycles = 0;
    while (!ev) begin
      if (cycles >= 64) begin
        n_checks++;
        n_err++;
        $display("FAIL run_one_timeout at %0t: got %0d cycles expected retirement", $time, cycles);
        return;
      end
      if (m_ph == PH_T) return;
      if ((reset_at > 0 && cycles == reset_at) || (rnd && $urandom_range(0, 99) == 0)) begin
        do_reset();
        return;
      end
      ir = (m_ph == PH_F) ? (rnd ? ($urandom_range(0, 3) != 0) : (il == 0)) : 1'($urandom);
      dr = (m_ph == PH_M) ? (rnd ? ($urandom_range(0, 3) != 0) : (dl == 0)) : 1'($urandom);
      if (m_ph == PH_F && !ir) il--;
      if (m_ph == PH_M && !dr) dl--;
      step(ir, dr, (m_ph == PH_F && ir) ? op : 6'($urandom),
           (m_ph == PH_F && ir) ? fn : 6'($urandom), ev);
      cycles++;
    end
  endtask

  logic [11:0] legal_tab [11] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2A}, {6'h00, 6'h08},
    {6'h08, 6'h00}, {6'h0E, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00},
    {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit ev;
    logic [5:0] op, fn;
    int idx;

    do_reset();

    run_one(6'h00, 6'h20, 0, 0, 1'b0, 0, c);
    chk("lat_add", 64'(c), 64'd4);
    chk("retired_after_add", 64'(retired), 64'd1);
    run_one(6'h23, 6'h11, 0, 3, 1'b0, 0, c);
    chk("lat_lw_dstall3", 64'(c), 64'd8);
    run_one(6'h05, 6'h00, 0, 0, 1'b0, 0, c);
    chk("lat_bne", 64'(c), 64'd3);
    run_one(6'h02, 6'h3F, 0, 0, 1'b0, 0, c);
    chk("lat_j", 64'(c), 64'd2);
    run_one(6'h00, 6'h08, 0, 0, 1'b0, 0, c);
    chk("lat_jr", 64'(c), 64'd2);
    run_one(6'h03, 6'h00, 0, 0, 1'b0, 0, c);
    chk("lat_jal", 64'(c), 64'd3);
    run_one(6'h2B, 6'h00, 0, 0, 1'b0, 0, c);
    chk("lat_sw", 64'(c), 64'd4);
    run_one(6'h0E, 6'h00, 2, 0, 1'b0, 0, c);
    chk("lat_xori_istall2", 64'(c), 64'd6);
    chk("retired_after_8", 64'(retired), 64'd8);

    run_one(6'h3F, 6'h00, 0, 0, 1'b0, 0, c);
    repeat (20) step(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), ev);
    chk("illegal_held", 64'(illegal), 64'd1);
    chk("trap_state", 64'(state), 64'd5);
    do_reset();
    #1;
    chk("illegal_cleared", 64'(illegal), 64'd0);
    chk("state_after_reset", 64'(state), 64'd0);

    run_one(6'h00, 6'h20, 0, 0, 1'b0, 0, c);
    run_one(6'h2B, 6'h00, 0, 10, 1'b0, 5, c);
    #1;
    chk("retired_after_sw_abort", 64'(retired), 64'd0);
    chk("imem_req_after_abort", 64'(imem_req), 64'd1);

    repeat (300) begin
      if ($urandom_range(0, 19) == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        idx = $urandom_range(0, 10);
        op  = legal_tab[idx][11:6];
        fn  = (op == 6'h00) ? legal_tab[idx][5:0] : 6'($urandom);
      end
      run_one(op, fn, 0, 0, 1'b1, 0, c);
      if (m_ph == PH_T) begin
        repeat ($urandom_range(3, 12))
          step(1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), ev);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
